// File: rtl/fft_peak_detect_if.sv
// Bin stream in / power stream, peak report and abort flag out for fft_peak_detect.
interface fft_peak_detect_if #(
  parameter int unsigned DATA_WID     = 16,
  parameter int unsigned LOG2_FFT_LEN = 6
);
  localparam int unsigned PWR_WID = 2 * DATA_WID;

  logic                       val_i;
  logic signed [DATA_WID-1:0] fft_data_re_i;
  logic signed [DATA_WID-1:0] fft_data_im_i;
  logic                       pwr_val_o;
  logic [PWR_WID-1:0]         pwr_o;
  logic [LOG2_FFT_LEN-1:0]    bin_o;
  logic                       peak_val_o;
  logic [LOG2_FFT_LEN-1:0]    peak_bin_o;
  logic [PWR_WID-1:0]         peak_pwr_o;
  logic                       err_o;

  // Upstream/consumer side: drives bins, observes results.
  modport master (
    output val_i, fft_data_re_i, fft_data_im_i,
    input  pwr_val_o, pwr_o, bin_o, peak_val_o, peak_bin_o, peak_pwr_o, err_o
  );

  // Detector side.
  modport slave (
    input  val_i, fft_data_re_i, fft_data_im_i,
    output pwr_val_o, pwr_o, bin_o, peak_val_o, peak_bin_o, peak_pwr_o, err_o
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-bin power |X|^2 and per-frame peak search on the serial FFT bin stream.
// Optional build macro PEAK_SKIP_DC_EN: bin 0 is excluded from the peak search
// (it is still streamed on pwr_o).
module fft_peak_detect #(
  parameter int unsigned DATA_WID     = 16,
  parameter int unsigned FFT_LEN      = 64,
  parameter int unsigned LOG2_FFT_LEN = 6
) (
  input logic              clk,
  input logic              rst_n,
  fft_peak_detect_if.slave bus
);
  localparam int unsigned PWR_WID = 2 * DATA_WID;
  localparam logic [LOG2_FFT_LEN-1:0] LAST_BIN = LOG2_FFT_LEN'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  logic [LOG2_FFT_LEN-1:0] bin_cnt;
  logic                    s1_val;
  logic [LOG2_FFT_LEN-1:0] s1_bin;
  logic signed [PWR_WID-1:0] s1_rr;
  logic signed [PWR_WID-1:0] s1_ii;

  state_t                  state;
  logic [PWR_WID-1:0]      max_pwr;
  logic [LOG2_FFT_LEN-1:0] max_bin;
  logic [PWR_WID-1:0]      nxt_pwr;
  logic [LOG2_FFT_LEN-1:0] nxt_bin;
  logic [PWR_WID-1:0]      seed_pwr;
  logic [LOG2_FFT_LEN-1:0] seed_bin;

  // Bin counter, abort detect and the two-stage power pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_cnt       <= '0;
      bus.err_o     <= 1'b0;
      s1_val        <= 1'b0;
      s1_bin        <= '0;
      s1_rr         <= '0;
      s1_ii         <= '0;
      bus.pwr_val_o <= 1'b0;
      bus.bin_o     <= '0;
      bus.pwr_o     <= '0;
    end else begin
      if (bus.val_i) begin
        bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + LOG2_FFT_LEN'(1);
      end else begin
        bin_cnt <= '0;
      end
      bus.err_o     <= !bus.val_i && (bin_cnt != '0);
      s1_val        <= bus.val_i;
      s1_bin        <= bin_cnt;
      s1_rr         <= PWR_WID'(bus.fft_data_re_i) * PWR_WID'(bus.fft_data_re_i);
      s1_ii         <= PWR_WID'(bus.fft_data_im_i) * PWR_WID'(bus.fft_data_im_i);
      bus.pwr_val_o <= s1_val;
      bus.bin_o     <= s1_bin;
      // Both squares are non-negative; the sum peaks at 2^(PWR_WID-1) so it cannot wrap.
      bus.pwr_o     <= PWR_WID'($unsigned(s1_rr)) + PWR_WID'($unsigned(s1_ii));
    end
  end

  // Running-max candidate (strict compare keeps the lower index on ties) and frame seed.
  always_comb begin
    nxt_pwr  = max_pwr;
    nxt_bin  = max_bin;
    seed_pwr = bus.pwr_o;
    seed_bin = bus.bin_o;
    if (bus.pwr_o > max_pwr) begin
      nxt_pwr = bus.pwr_o;
      nxt_bin = bus.bin_o;
    end
`ifdef PEAK_SKIP_DC_EN
    // Seeding as (bin 1, power 0) makes bin 1 win by default and ignores bin 0.
    seed_pwr = '0;
    seed_bin = LOG2_FFT_LEN'(1);
`endif
  end

  // Frame FSM on stage-2 data: seed on bin 0, accumulate, report after the last bin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      max_pwr        <= '0;
      max_bin        <= '0;
      bus.peak_val_o <= 1'b0;
      bus.peak_bin_o <= '0;
      bus.peak_pwr_o <= '0;
    end else begin
      bus.peak_val_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.pwr_val_o && (bus.bin_o == '0)) begin
            state   <= ACC;
            max_pwr <= seed_pwr;
            max_bin <= seed_bin;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          if (!bus.pwr_val_o) begin
            // Stream gap inside a frame: aborted frame has drained, drop the partial max.
            state <= IDLE;
          end else begin
            max_pwr <= nxt_pwr;
            max_bin <= nxt_bin;
            if (bus.bin_o == LAST_BIN) begin
              state          <= DONE;
              bus.peak_val_o <= 1'b1;
              bus.peak_bin_o <= nxt_bin;
              bus.peak_pwr_o <= nxt_pwr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
